acb_operand_mover: RTL and testbench

- Parametrised ACB bus master that sits between an accelerator core and the ACB memory request/response pipes.
- On a start pulse it does the following in order:
  - reads NUM_RD 64-bit operand words from consecutive addresses starting at src_addr;
  - presents them to the core and waits for job_done;
  - writes NUM_WR 64-bit result words to consecutive addresses starting at dst_addr;
  - pulses done.
- It adds multi-word bursts, programmable base addresses, write-response tracking, error reporting and a start/busy handshake.

---
 rtl/acb_pkg.sv | 38 +++
 rtl/acb_req_formatter.sv | 25 ++
 rtl/acb_operand_mover.sv | 160 ++++++++++++++++
 tb/tb_acb_operand_mover.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/acb_pkg.sv
// acb_pkg: shared ACB field layout, command codes, master state encoding and address helper.
//   Request word (110b): [109:108] cmd, [107:100] byte mask, [99:64] address, [63:0] write data.
//   Response word (65b): [64] error, [63:0] data.
package acb_pkg;

    localparam int ADDR_W = 36;
    localparam int DATA_W = 64;
    localparam int CMD_W  = 2;
    localparam int MASK_W = 8;
    localparam int REQ_W  = 110;
    localparam int RSP_W  = 65;

    localparam int REQ_DATA_LSB = 0;
    localparam int REQ_ADDR_LSB = 64;
    localparam int REQ_MASK_LSB = 100;
    localparam int REQ_CMD_LSB  = 108;
    localparam int RSP_ERR_BIT  = 64;

    localparam logic [CMD_W-1:0]  ACB_CMD_READ      = 2'b01;
    localparam logic [CMD_W-1:0]  ACB_CMD_WRITE     = 2'b00;
    localparam logic [MASK_W-1:0] ACB_BYTE_MASK_ALL = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_RSP  = 3'd2,
        ST_OP_WAIT = 3'd3,
        ST_WR_REQ  = 3'd4,
        ST_WR_RSP  = 3'd5,
        ST_DONE    = 3'd6
    } acb_state_e;

    // Address of 64-bit word k above base: low three bits dropped, wraps silently modulo 2^36.
    function automatic logic [ADDR_W-1:0] acb_word_addr(input logic [ADDR_W-1:0] base, input logic [7:0] k);
        return (base & ~ADDR_W'(7)) + (ADDR_W'(k) << 3);
    endfunction

endpackage

// File: rtl/acb_req_formatter.sv
// acb_req_formatter: combinational packing of one ACB request word.
//   cmd  : command code (read/write)
//   mask : byte mask
//   addr : byte address
//   data : write data (zero for reads)
//   req  : packed 110-bit request word
module acb_req_formatter
    import acb_pkg::*;
(
    input  logic [CMD_W-1:0]  cmd,
    input  logic [MASK_W-1:0] mask,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    output logic [REQ_W-1:0]  req
);

    always_comb begin
        req = '0;
        req[REQ_CMD_LSB  +: CMD_W]  = cmd;
        req[REQ_MASK_LSB +: MASK_W] = mask;
        req[REQ_ADDR_LSB +: ADDR_W] = addr;
        req[REQ_DATA_LSB +: DATA_W] = data;
    end

endmodule

// File: rtl/acb_operand_mover.sv
// acb_operand_mover: ACB bus master that reads NUM_RD operand words, hands them to the core, writes back NUM_WR results.
//   clk, reset       : clock, synchronous active-high reset
//   start            : job start pulse, accepted only when idle
//   src_addr/dst_addr: operand / result base byte addresses
//   busy             : high whenever not idle
//   operands(_valid) : operand words and their valid flag (OP_WAIT)
//   job_done, result : core completion and result words
//   done, error      : one-cycle completion pulse, sticky per-job error flag
//   ACB_*_REQUEST_*  : request pipe (read_data word, read_req = ready, read_ack = valid)
//   ACB_*_RESPONSE_* : response pipe (write_data word, write_req = valid, write_ack = ready)
module acb_operand_mover #(
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1,
    parameter int ADDR_W = 36,
    parameter int CNT_W  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [ADDR_W-1:0]         src_addr,
    input  logic [ADDR_W-1:0]         dst_addr,
    output logic                      busy,
    output logic [64*NUM_RD-1:0]      operands,
    output logic                      operands_valid,
    input  logic                      job_done,
    input  logic [64*NUM_WR-1:0]      result,
    output logic                      done,
    output logic                      error,
    output logic [acb_pkg::REQ_W-1:0] ACB_ACCELERATOR_MEM_REQUEST_pipe_read_data,
    input  logic                      ACB_ACCELERATOR_MEM_REQUEST_pipe_read_req,
    output logic                      ACB_ACCELERATOR_MEM_REQUEST_pipe_read_ack,
    input  logic [acb_pkg::RSP_W-1:0] ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_data,
    input  logic                      ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_req,
    output logic                      ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_ack
);

    import acb_pkg::*;

    acb_state_e                      state, state_n;
    logic [CNT_W-1:0]                cnt, cnt_n;
    logic [ADDR_W-1:0]               src_q, src_n, dst_q, dst_n;
    logic [NUM_RD-1:0][DATA_W-1:0]   ops, ops_n;
    logic [NUM_WR-1:0][DATA_W-1:0]   wbuf, wbuf_n;
    logic                            err_q, err_n;
    logic                            req_xfer, rsp_xfer, rsp_err;
    logic                            last_rd, last_wr, wr_phase, ack_n;
    logic [DATA_W-1:0]               rsp_word, wr_word;
    logic [ADDR_W-1:0]               req_addr;
    logic [REQ_W-1:0]                req_n;

    assign req_xfer = ACB_ACCELERATOR_MEM_REQUEST_pipe_read_ack & ACB_ACCELERATOR_MEM_REQUEST_pipe_read_req;
    assign rsp_xfer = ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_ack & ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_req;
    assign rsp_err  = ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_data[RSP_ERR_BIT];
    assign rsp_word = ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_data[DATA_W-1:0];
    assign last_rd  = cnt == CNT_W'(NUM_RD - 1);
    assign last_wr  = cnt == CNT_W'(NUM_WR - 1);

    assign busy           = state != ST_IDLE;
    assign operands_valid = state == ST_OP_WAIT;
    assign done           = state == ST_DONE;
    assign error          = err_q;
    assign operands       = ops;
    assign ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_ack = (state == ST_RD_RSP) || (state == ST_WR_RSP);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        src_n   = src_q;
        dst_n   = dst_q;
        ops_n   = ops;
        wbuf_n  = wbuf;
        err_n   = err_q;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    src_n   = src_addr;
                    dst_n   = dst_addr;
                    err_n   = 1'b0;
                    cnt_n   = '0;
                    state_n = ST_RD_REQ;
                end
            end
            ST_RD_REQ: state_n = req_xfer ? ST_RD_RSP : ST_RD_REQ;
            ST_RD_RSP: begin
                if (rsp_xfer && rsp_err) begin
                    err_n   = 1'b1;
                    state_n = ST_DONE;
                end else if (rsp_xfer) begin
                    for (int i = 0; i < NUM_RD; i++)
                        if (cnt == CNT_W'(i)) ops_n[i] = rsp_word;
                    cnt_n   = last_rd ? '0 : cnt + 1'b1;
                    state_n = last_rd ? ST_OP_WAIT : ST_RD_REQ;
                end
            end
            ST_OP_WAIT: begin
                if (job_done) begin
                    wbuf_n  = result;
                    cnt_n   = '0;
                    state_n = ST_WR_REQ;
                end
            end
            ST_WR_REQ: state_n = req_xfer ? ST_WR_RSP : ST_WR_REQ;
            ST_WR_RSP: begin
                if (rsp_xfer && rsp_err) begin
                    err_n   = 1'b1;
                    state_n = ST_DONE;
                end else if (rsp_xfer) begin
                    cnt_n   = last_wr ? cnt : cnt + 1'b1;
                    state_n = last_wr ? ST_DONE : ST_WR_REQ;
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // The request word is built from next-cycle values so it is registered and valid
    // in the first cycle of RD_REQ/WR_REQ, and unchanged while the request is stalled.
    always_comb begin
        wr_word = '0;
        for (int i = 0; i < NUM_WR; i++)
            if (cnt_n == CNT_W'(i)) wr_word = wbuf_n[i];
        wr_phase = state_n == ST_WR_REQ;
        ack_n    = (state_n == ST_RD_REQ) || wr_phase;
        req_addr = acb_word_addr(wr_phase ? dst_n : src_n, 8'(cnt_n));
    end

    acb_req_formatter u_fmt (
        .cmd  (wr_phase ? ACB_CMD_WRITE : ACB_CMD_READ),
        .mask (ACB_BYTE_MASK_ALL),
        .addr (req_addr),
        .data (wr_phase ? wr_word : '0),
        .req  (req_n)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            src_q <= '0;
            dst_q <= '0;
            ops   <= '0;
            wbuf  <= '0;
            err_q <= 1'b0;
            ACB_ACCELERATOR_MEM_REQUEST_pipe_read_ack  <= 1'b0;
            ACB_ACCELERATOR_MEM_REQUEST_pipe_read_data <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            src_q <= src_n;
            dst_q <= dst_n;
            ops   <= ops_n;
            wbuf  <= wbuf_n;
            err_q <= err_n;
            ACB_ACCELERATOR_MEM_REQUEST_pipe_read_ack  <= ack_n;
            ACB_ACCELERATOR_MEM_REQUEST_pipe_read_data <= req_n;
        end
    end

endmodule

// File: tb/tb_acb_operand_mover.sv
// tb_acb_operand_mover: table-driven jobs against a memory model, with an expected-request scoreboard.
module tb_acb_operand_mover;

    localparam int NUM_RD = 2;
    localparam int NUM_WR = 1;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   start = 1'b0;
    logic [35:0]            src_addr = '0;
    logic [35:0]            dst_addr = '0;
    logic                   busy;
    logic [64*NUM_RD-1:0]   operands;
    logic                   operands_valid;
    logic                   job_done = 1'b0;
    logic [64*NUM_WR-1:0]   result = '0;
    logic                   done;
    logic                   error;
    logic [109:0]           rq_data;
    logic                   rq_req;
    logic                   rq_ack;
    logic [64:0]            rs_data;
    logic                   rs_req;
    logic                   rs_ack;

    acb_operand_mover #(.NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .ADDR_W(36), .CNT_W(4)) dut (
        .clk                                          (clk),
        .reset                                        (reset),
        .start                                        (start),
        .src_addr                                     (src_addr),
        .dst_addr                                     (dst_addr),
        .busy                                         (busy),
        .operands                                     (operands),
        .operands_valid                               (operands_valid),
        .job_done                                     (job_done),
        .result                                       (result),
        .done                                         (done),
        .error                                        (error),
        .ACB_ACCELERATOR_MEM_REQUEST_pipe_read_data   (rq_data),
        .ACB_ACCELERATOR_MEM_REQUEST_pipe_read_req    (rq_req),
        .ACB_ACCELERATOR_MEM_REQUEST_pipe_read_ack    (rq_ack),
        .ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_data (rs_data),
        .ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_req  (rs_req),
        .ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_ack  (rs_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [35:0] src;
        logic [35:0] dst;
        logic [63:0] op0;
        logic [63:0] op1;
        logic [63:0] res;
        int          rd_err;
        bit          wr_err;
        bit          exp_err;
    } vec_t;

    vec_t          vecs[6];
    logic [109:0]  exp_q[$];
    logic [63:0]   mem [logic [35:0]];
    int            checks = 0;
    int            errors = 0;
    bit            err_rd_en = 1'b0;
    logic [35:0]   err_rd_addr = '0;
    bit            wr_err_en = 1'b0;
    int            stall_limit = 0;
    int            stall_total = 0;
    int            done_total = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model: samples at negedge, answers a transferred request with a zero-wait response.
    initial begin
        logic         req_x, rsp_x, holding;
        logic [64:0]  rsp_n;
        logic [109:0] held;
        logic [35:0]  a;
        rq_req  = 1'b1;
        rs_req  = 1'b0;
        rs_data = '0;
        holding = 1'b0;
        held    = '0;
        rsp_n   = '0;
        forever begin
            @(negedge clk);
            req_x = rq_ack && rq_req;
            rsp_x = rs_req && rs_ack;
            if (done) done_total++;
            if (rq_ack && !rq_req) begin
                if (holding) chk("req_hold", rq_data, held);
                held = rq_data;
                holding = 1'b1;
                stall_total++;
            end else begin
                holding = 1'b0;
            end
            if (req_x) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_req", rq_data, '0);
                    if (rq_data == '0) chk("unexpected_req_zero", 1, 0);
                end else begin
                    chk("req", rq_data, exp_q.pop_front());
                end
                a = rq_data[99:64];
                if (rq_data[109:108] == 2'b01)
                    rsp_n = {err_rd_en && a == err_rd_addr, mem.exists(a) ? mem[a] : 64'h0};
                else begin
                    mem[a] = rq_data[63:0];
                    rsp_n = {wr_err_en, 64'h0};
                end
            end
            @(posedge clk);
            #1;
            if (rsp_x) rs_req = 1'b0;
            if (req_x) begin
                rs_req  = 1'b1;
                rs_data = rsp_n;
            end
            rq_req = stall_total >= stall_limit;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic run_job(input vec_t v, input int stall, input bit poke);
        logic [35:0] b0, b1, d;
        int d0, s0;
        b0 = v.src & ~36'h7;
        b1 = b0 + 36'd8;
        d  = v.dst & ~36'h7;
        mem[b0] = v.op0;
        mem[b1] = v.op1;
        err_rd_en   = v.rd_err >= 0;
        err_rd_addr = v.rd_err == 1 ? b1 : b0;
        wr_err_en   = v.wr_err;
        exp_q.push_back({2'b01, 8'hFF, b0, 64'h0});
        if (v.rd_err != 0) exp_q.push_back({2'b01, 8'hFF, b1, 64'h0});
        if (v.rd_err < 0) exp_q.push_back({2'b00, 8'hFF, d, v.res});
        d0 = done_total;
        s0 = stall_total;
        stall_limit = stall_total + stall;
        @(negedge clk);
        start = 1'b1;
        src_addr = v.src;
        dst_addr = v.dst;
        @(negedge clk);
        start = 1'b0;
        if (poke) begin
            for (int i = 0; i < 100 && !rs_ack; i++) @(negedge clk);
            start = 1'b1;
            job_done = 1'b1;
            src_addr = 36'h7_7770;
            @(negedge clk);
            start = 1'b0;
            job_done = 1'b0;
        end
        if (v.rd_err < 0) begin
            for (int i = 0; i < 200 && !operands_valid; i++) @(negedge clk);
            chk("operands_valid", operands_valid, 1);
            chk("operands", operands, {v.op1, v.op0});
            job_done = 1'b1;
            result = v.res;
            @(negedge clk);
            job_done = 1'b0;
        end
        for (int i = 0; i < 200 && !done; i++) @(negedge clk);
        chk("done_seen", done, 1);
        repeat (3) @(negedge clk);
        chk("done_pulses", done_total - d0, 1);
        chk("error", error, v.exp_err);
        chk("busy_after", busy, 0);
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("stall_cycles", stall_total - s0, stall);
        if (!v.exp_err) chk("mem_write", mem[d], v.res);
        exp_q.delete();
    endtask

    initial begin
        vecs[0] = '{36'h1000,      36'h2000, 64'hAAAA,          64'hBBBB,          64'h1234,          -1, 1'b0, 1'b0};
        vecs[1] = '{36'hF_FFFF_FFF8, 36'h4000, 64'h1111_2222,   64'h3333_4444,     64'hDEAD_BEEF,     -1, 1'b0, 1'b0};
        vecs[2] = '{36'h1000,      36'h2000, 64'h5555,          64'h6666,          64'h7777,           0, 1'b0, 1'b1};
        vecs[3] = '{36'h8000,      36'h9000, 64'h0102_0304,     64'h0506_0708,     64'h99,             1, 1'b0, 1'b1};
        vecs[4] = '{36'hA000,      36'hB000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,      64'hCAFE,          -1, 1'b1, 1'b1};
        vecs[5] = '{36'h3004,      36'h500C, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'h8000_0000_0000_0001, -1, 1'b0, 1'b0};

        repeat (4) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_opvalid", operands_valid, 0);
        chk("rst_rq_ack", rq_ack, 0);
        chk("rst_rs_ack", rs_ack, 0);
        chk("rst_rq_data", rq_data, 0);
        chk("rst_operands", operands, 0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_job(vecs[i], 0, 1'b0);

        // Request backpressure for five cycles on the first read.
        run_job(vecs[0], 5, 1'b0);

        // start and job_done while reading: both must be ignored.
        run_job(vecs[5], 0, 1'b1);

        // Reset in OP_WAIT, then a clean job.
        mem[36'h6000] = 64'h42;
        mem[36'h6008] = 64'h43;
        err_rd_en = 1'b0;
        exp_q.push_back({2'b01, 8'hFF, 36'h6000, 64'h0});
        exp_q.push_back({2'b01, 8'hFF, 36'h6008, 64'h0});
        start = 1'b1;
        src_addr = 36'h6000;
        dst_addr = 36'h7000;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 200 && !operands_valid; i++) @(negedge clk);
        chk("pre_reset_opvalid", operands_valid, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_opvalid", operands_valid, 0);
        chk("mid_rst_rq_ack", rq_ack, 0);
        chk("mid_rst_rs_ack", rs_ack, 0);
        chk("mid_rst_operands", operands, 0);
        reset = 1'b0;
        chk("mid_rst_scoreboard", exp_q.size(), 0);
        exp_q.delete();
        @(negedge clk);
        run_job(vecs[1], 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
